// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying a control field and a payload field between pipeline stages.
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 48
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble control zeroing,
// an optional skid entry for a registered in_ready, and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 48,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_cnt,
  pipe_stage_reg_if.slave   in_if,
  pipe_stage_reg_if.master  out_if,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic in_ready;
  logic in_xfer;
  logic out_xfer;

  // With a skid entry, in_ready depends only on flop state, breaking the ready path.
  assign in_ready = (SKID != 0) ? ~skid_valid_q : (out_if.ready | ~main_valid_q);
  assign in_xfer  = in_if.valid & in_ready;
  assign out_xfer = main_valid_q & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid_q;
  assign out_if.ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_if.data  = main_data_q;
  assign bubble_cnt   = cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      // Main is free this edge: the older skid entry always moves up before new input.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_ctrl_d = in_if.ctrl;
          skid_data_d = in_if.data;
        end
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) begin
          main_ctrl_d = in_if.ctrl;
          main_data_d = in_if.data;
        end
      end
    end else if (in_xfer && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_if.ctrl;
      skid_data_d  = in_if.data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (!main_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no skid, skid with 4-bit counter) share one
// stimulus stream; each is compared against a capacity-limited FIFO reference model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        clr_cnt;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [47:0] in_data;
  logic        out_ready;

  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  logic [2:0]  obs_valid, obs_ready;
  logic [7:0]  obs_ctrl [3];
  logic [47:0] obs_data [3];
  logic [15:0] obs_cnt  [3];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance an ordered list of held entries plus a bubble count.
  int          m_n   [3];
  logic [7:0]  m_c   [3][2];
  logic [47:0] m_d   [3][2];
  int          m_cnt [3];

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(48)) i0(), o0(), i1(), o1(), i2(), o2();

  assign i0.valid = in_valid; assign i0.ctrl = in_ctrl; assign i0.data = in_data;
  assign i1.valid = in_valid; assign i1.ctrl = in_ctrl; assign i1.data = in_data;
  assign i2.valid = in_valid; assign i2.ctrl = in_ctrl; assign i2.data = in_data;
  assign o0.ready = out_ready;
  assign o1.ready = out_ready;
  assign o2.ready = out_ready;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(48), .SKID(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_if(i0), .out_if(o0), .bubble_cnt(cnt0));
  pipe_stage_reg #(.CTRL_W(8), .DATA_W(48), .SKID(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_if(i1), .out_if(o1), .bubble_cnt(cnt1));
  pipe_stage_reg #(.CTRL_W(8), .DATA_W(48), .SKID(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_if(i2), .out_if(o2), .bubble_cnt(cnt2));

  assign obs_valid = {o2.valid, o1.valid, o0.valid};
  assign obs_ready = {i2.ready, i1.ready, i0.ready};
  assign obs_ctrl[0] = o0.ctrl; assign obs_ctrl[1] = o1.ctrl; assign obs_ctrl[2] = o2.ctrl;
  assign obs_data[0] = o0.data; assign obs_data[1] = o1.data; assign obs_data[2] = o2.data;
  assign obs_cnt[0] = cnt0; assign obs_cnt[1] = cnt1; assign obs_cnt[2] = {12'h000, cnt2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_rdy(int d);
    if (d != 1) return (m_n[d] < 2);
    return (out_ready || (m_n[d] == 0));
  endfunction

  function automatic int cnt_max(int d);
    return (d == 2) ? 15 : 65535;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      m_n[d] = 0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic tick();
    bit rdy [3];
    bit ix, ox;
    for (int d = 0; d < 3; d++) rdy[d] = m_rdy(d);
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      ix = in_valid && rdy[d];
      ox = (m_n[d] > 0) && out_ready;
      if (clr_cnt) m_cnt[d] = 0;
      else if (m_n[d] == 0 && m_cnt[d] < cnt_max(d)) m_cnt[d]++;
      if (flush) begin
        m_n[d] = 0;
      end else begin
        if (ox) begin
          m_c[d][0] = m_c[d][1];
          m_d[d][0] = m_d[d][1];
          m_n[d]--;
        end
        if (ix) begin
          m_c[d][m_n[d]] = in_ctrl;
          m_d[d][m_n[d]] = in_data;
          m_n[d]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_ctrl = 8'h00; in_data = 48'h0;
    flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_ctrl = 8'hFF; out_ready = 1'b0;
    rst = 1'b1;
    clear_model();
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_ready[d] !== 1'b1) begin
        miscompares++; $display("FAIL reset_in_ready dut%0d got %b want 1", d, obs_ready[d]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_valid[d] !== 1'b0 || obs_ctrl[d] !== 8'h00 || obs_data[d] !== 48'h0 ||
          obs_cnt[d] !== 16'h0 || obs_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got v=%b c=%h d=%h cnt=%0d r=%b want 0/0/0/0/1",
                 d, obs_valid[d], obs_ctrl[d], obs_data[d], obs_cnt[d], obs_ready[d]);
      end
    end
    idle_inputs();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_bubble_cnt();
    do_reset();
    repeat (5) tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_cnt[d] !== 16'd5) begin
        miscompares++; $display("FAIL bubble_5 dut%0d got %0d want 5", d, obs_cnt[d]);
      end
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_cnt[d] !== 16'd0) begin
        miscompares++; $display("FAIL bubble_clr dut%0d got %0d want 0", d, obs_cnt[d]);
      end
    end
    do_reset();
    repeat (20) tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_cnt[d] !== ((d == 2) ? 16'd15 : 16'd20)) begin
        miscompares++;
        $display("FAIL bubble_sat dut%0d got %0d want %0d", d, obs_cnt[d], (d == 2) ? 15 : 20);
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 48'h123456789ABC; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_ctrl = 8'h00; in_data = 48'h0;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_valid[d] !== 1'b1 || obs_ctrl[d] !== 8'hA5 || obs_data[d] !== 48'h123456789ABC) begin
        miscompares++;
        $display("FAIL fill dut%0d got v=%b c=%h d=%h want 1/a5/123456789abc",
                 d, obs_valid[d], obs_ctrl[d], obs_data[d]);
      end
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_valid[d] !== 1'b0 || obs_ctrl[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL drain dut%0d got v=%b c=%h want 0/00", d, obs_valid[d], obs_ctrl[d]);
      end
    end
  endtask

  task automatic test_stall();
    int next_in;
    int k;
    logic [7:0] got [4];
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'd1; in_data = 48'h1111; out_ready = 1'b0;
    tick();
    in_ctrl = 8'd2; in_data = 48'h2222;
    tick();
    in_ctrl = 8'd3; in_data = 48'h3333;
    #1;
    vectors++;
    if (obs_ready[0] !== 1'b0) begin
      miscompares++; $display("FAIL stall_in_ready got %b want 0", obs_ready[0]);
    end
    repeat (3) begin
      tick();
      vectors++;
      if (obs_valid[0] !== 1'b1 || obs_ctrl[0] !== 8'd1 || obs_data[0] !== 48'h1111) begin
        miscompares++;
        $display("FAIL stall_hold got v=%b c=%h d=%h want 1/01/1111",
                 obs_valid[0], obs_ctrl[0], obs_data[0]);
      end
    end
    out_ready = 1'b1;
    next_in = 3;
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (next_in <= 3);
      in_ctrl = 8'(next_in);
      in_data = 48'h1111 * 48'(next_in);
      #1;
      if (obs_valid[0] && k < 4) begin
        got[k] = obs_ctrl[0];
        k++;
      end
      if (obs_ready[0] && in_valid) next_in++;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (k !== 3) begin
      miscompares++; $display("FAIL stall_count got %0d want 3", k);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (got[j] !== 8'(j + 1)) begin
          miscompares++; $display("FAIL stall_order idx%0d got %h want %h", j, got[j], 8'(j + 1));
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'd7; in_data = 48'h7; out_ready = 1'b0;
    tick();
    in_ctrl = 8'd8; in_data = 48'h8;
    tick();
    in_ctrl = 8'd9; in_data = 48'h9; out_ready = 1'b1; flush = 1'b1;
    #1;
    vectors++;
    if (obs_ready[1] !== 1'b1) begin
      miscompares++; $display("FAIL flush_ready_noskid got %b want 1", obs_ready[1]);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs_valid[d] !== 1'b0 || obs_ctrl[d] !== 8'h00 || obs_ready[d] !== 1'b1) begin
          miscompares++;
          $display("FAIL flush cyc%0d dut%0d got v=%b c=%h r=%b want 0/00/1",
                   cyc, d, obs_valid[d], obs_ctrl[d], obs_ready[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      in_valid = (i < 100);
      in_ctrl = 8'(i);
      in_data = {16'($urandom), 32'($urandom)};
      #1;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if ((i < 100 && obs_ready[d] !== 1'b1) ||
            (i >= 1 && (obs_valid[d] !== 1'b1 || obs_ctrl[d] !== 8'(i - 1))) ||
            (i == 0 && obs_valid[d] !== 1'b0) ||
            (obs_valid[d] && obs_data[d] !== m_d[d][0])) begin
          miscompares++;
          $display("FAIL b2b cyc%0d dut%0d got v=%b c=%h r=%b want 1/%h/1",
                   i, d, obs_valid[d], obs_ctrl[d], obs_ready[d], 8'(i - 1));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_valid[d] !== 1'b0) begin
        miscompares++; $display("FAIL b2b_end dut%0d got %b want 0", d, obs_valid[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = 48'h11; out_ready = 1'b0;
    tick();
    in_ctrl = 8'h22; in_data = 48'h22;
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (obs_ready[0] !== 1'b0 || obs_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_async got r=%b v=%b want 0/1", obs_ready[0], obs_valid[0]);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs_valid[d] !== 1'b0 || obs_ready[d] !== 1'b1 || obs_ctrl[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL async_rst dut%0d got v=%b r=%b c=%h want 0/1/00",
                 d, obs_valid[d], obs_ready[d], obs_ctrl[d]);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      clr_cnt   = ($urandom_range(0, 29) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = {16'($urandom), 32'($urandom)};
      #1;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs_valid[d] !== (m_n[d] > 0) || obs_ready[d] !== m_rdy(d) ||
            obs_ctrl[d] !== ((m_n[d] > 0) ? m_c[d][0] : 8'h00) ||
            (m_n[d] > 0 && obs_data[d] !== m_d[d][0]) ||
            obs_cnt[d] !== 16'(m_cnt[d])) begin
          miscompares++;
          $display("FAIL random cyc%0d dut%0d got v=%b r=%b c=%h d=%h cnt=%0d want v=%b r=%b c=%h d=%h cnt=%0d",
                   cyc, d, obs_valid[d], obs_ready[d], obs_ctrl[d], obs_data[d], obs_cnt[d],
                   (m_n[d] > 0), m_rdy(d), (m_n[d] > 0) ? m_c[d][0] : 8'h00, m_d[d][0], m_cnt[d]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    clear_model();
    test_reset();
    test_bubble_cnt();
    test_fill();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register. It replaces the fixed-width, always-loading stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Adds a valid/ready handshake, stall via back-pressure, synchronous flush, and bubble insertion that zeroes control bits.
- Optional skid entry keeps full throughput when in_ready is registered.
- Includes a saturating bubble counter for CPI profiling.

Parameters:
- CTRL_W, 8, width of control field (regWr, memRd, memWr, aluOp, ...); forced to 0 in bubbles.
- DATA_W, 48, width of payload field (operands, immediates, register ids, pcPlus1); not cleared by bubbles.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of bubble counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous squash of all held entries (branch taken / hazard).
- in_valid  input  1  upstream stage presents a valid instruction.
- in_ready  output  1  this stage accepts in_* this cycle.
- in_ctrl  input  CTRL_W  control bits from upstream.
- in_data  input  DATA_W  payload from upstream.
- out_valid  output  1  out_* holds a valid instruction.
- out_ready  input  1  downstream consumes this cycle; 0 = stall.
- out_ctrl  output  CTRL_W  control bits; all-zero whenever out_valid=0.
- out_data  output  DATA_W  payload of head entry.
- bubble_cnt  output  CNT_W  cycles with out_valid=0, saturating.
- clr_cnt  input  1  synchronous clear of bubble_cnt.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_ctrl=0, out_data=0, skid entry empty and zeroed, in_ready=1, bubble_cnt=0. in_ready=1 remains in effect during reset.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency is 1 cycle from input transfer to out_valid, when the main register is empty or draining.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Main register loads on input transfer.
  - On output transfer without input transfer, out_valid goes to 0.
- SKID=1:
  - in_ready = ~skid_full (registered).
  - If the main register is occupied and not draining, an input transfer goes to the skid entry.
  - When main drains, the skid entry moves to main the same edge, and any new input transfer goes to skid.
  - Order is preserved: skid contents always leave before new input.
  - Sustained throughput is 1 instruction/cycle; a full skid with out_ready=0 holds both entries indefinitely.
- Stall (out_ready=0 with out_valid=1): out_ctrl and out_data held bit-stable.
- Flush:
  - Next edge: out_valid=0, skid empty, out_ctrl=0. Data fields may keep stale values.
  - Flush has priority over a simultaneous input transfer; the incoming instruction is dropped.
  - in_ready stays as its formula dictates in the flush cycle, so the dropped instruction counts as consumed upstream.
- Bubble output: out_ctrl = 0 whenever out_valid=0, so downstream never sees a spurious regWr/memWr.
- bubble_cnt:
  - Increments each edge where out_valid=0 (sampled pre-edge) and rst=0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment and sets the counter to 0.
- Reset mid-operation: all entries are lost immediately; no partial transfers are preserved.
- No X propagation: in_ctrl and in_data are ignored when in_valid=0.

Test Plan:
- Reset/fill: rst pulse, then in_valid=1 with in_ctrl=8'hA5, in_data=48'h123456789ABC, out_ready=1 → next cycle out_valid=1, out_ctrl=A5, out_data=123456789ABC; 1 cycle latency.
- Stall with SKID=1: stream ctrl 1,2,3 with out_ready=0 from cycle 2 → in_ready drops after 2 accepted. Out holds 1 stable; release gives 1,2,3 in order with no loss or duplicate.
- Flush collision: main holds ctrl=7, skid holds 8, flush=1 together with in_valid=1 ctrl=9 → next cycle out_valid=0, out_ctrl=0, skid empty; 9 never appears.
- Back-to-back throughput: in_valid=1 and out_ready=1 for 100 cycles with ctrl incrementing → 100 outputs on consecutive cycles, for both SKID=0 and SKID=1.
- Bubble counter: idle 5 cycles after reset → bubble_cnt=5; clr_cnt and idle together → 0. With CNT_W=4, idle 20 cycles → 15, saturated.
- Async reset mid-stall: full skid, assert rst between edges → out_valid=0 and in_ready=1 immediately, before the next clk edge.
